p_s_converter: RTL and testbench

Parallel-to-serial converter that sits directly upstream of the serial-to-parallel converter and drives its serial D input. It accepts one C_BITS_IN-bit word per frame over a valid/ready handshake and shifts it out MSB-first in the last C_BITS_IN cycles of each C_FRAME_LEN-cycle frame. The word therefore lands in the downstream shift chain with the oldest bit (MSB) at the top index. FRAME_END marks the frame boundary for alignment and checking.

---
 rtl/s_p_pkg.sv | 21 ++
 rtl/p_s_frame_counter.sv | 51 +++++
 rtl/p_s_converter.sv | 164 ++++++++++++++++
 tb/tb_p_s_converter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/s_p_pkg.sv
// ---------------------------------------------------------------------------
// s_p_pkg
// Shared definitions for the parallel/serial converter pair
// (p_s_converter upstream, s_p_converter downstream).
//   C_BITS_DEFAULT      : default parallel word width
//   C_FRAME_LEN_DEFAULT : default frame period in clock cycles
//   state_e             : frame-phase state encoding used by both sides
// ---------------------------------------------------------------------------
package s_p_pkg;

  localparam int C_BITS_DEFAULT      = 8;
  localparam int C_FRAME_LEN_DEFAULT = 250;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_e;

endpackage

// File: rtl/p_s_frame_counter.sv
// ---------------------------------------------------------------------------
// p_s_frame_counter
// Free-running mod-C_FRAME_LEN frame counter with synchronous reset.
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset (cnt -> 0)
//   cnt       out  current position in the frame, 0..C_FRAME_LEN-1
//   load_tick out  high while cnt == S-1 (S = C_FRAME_LEN - C_BITS_IN)
//   load_next out  high when the next cycle will be the load cycle
//   frame_end out  high while cnt == C_FRAME_LEN-1
// ---------------------------------------------------------------------------
module p_s_frame_counter
  import s_p_pkg::*;
#(
  parameter int C_BITS_IN   = C_BITS_DEFAULT,
  parameter int C_FRAME_LEN = C_FRAME_LEN_DEFAULT,
  localparam int CW         = (C_FRAME_LEN > 1) ? $clog2(C_FRAME_LEN) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] cnt,
  output logic          load_tick,
  output logic          load_next,
  output logic          frame_end
);

  localparam logic [CW-1:0] END_CNT  = CW'(C_FRAME_LEN - 1);
  localparam logic [CW-1:0] LOAD_CNT = CW'(C_FRAME_LEN - C_BITS_IN - 1);

  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt + 1'b1;
    if (cnt == END_CNT) begin
      cnt_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  assign load_tick = (cnt == LOAD_CNT);
  assign load_next = (cnt_next == LOAD_CNT);
  assign frame_end = (cnt == END_CNT);

endmodule

// File: rtl/p_s_converter.sv
// ---------------------------------------------------------------------------
// p_s_converter
// Parallel-to-serial converter. Accepts one C_BITS_IN-bit word per frame
// over a valid/ready handshake and shifts it out MSB-first during the last
// C_BITS_IN cycles of each C_FRAME_LEN-cycle frame.
//
// Handshake: a word transfers on every rising CK edge where DIN_VALID and
// DIN_READY are both high. DIN_READY does not depend on DIN_VALID. When
// DIN_READY is low the source must hold DIN/DIN_VALID stable.
//
// Ports:
//   CK         in   clock
//   RST        in   synchronous active-high reset
//   DIN        in   parallel word
//   DIN_VALID  in   DIN is valid
//   DIN_READY  out  block can accept DIN this cycle
//   SO         out  serial data, MSB first, feeds downstream D
//   SO_VALID   out  SO carries bits of an accepted (or held) word
//   FRAME_END  out  high in the last cycle of each frame
//   UNDERRUN   out  one-cycle pulse after a load cycle with no word
//   FSM_STATE  out  current frame phase (IDLE/LOAD/SHIFT/GAP), debug view
//
// Build option: define P_S_UNDERRUN_HOLD_EN to repeat the previous word
// (with SO_VALID high) on underrun instead of sending invalid zeros.
// ---------------------------------------------------------------------------
module p_s_converter
  import s_p_pkg::*;
#(
  parameter int C_BITS_IN   = C_BITS_DEFAULT,
  parameter int C_FRAME_LEN = C_FRAME_LEN_DEFAULT
) (
  input  logic                 CK,
  input  logic                 RST,
  input  logic [C_BITS_IN-1:0] DIN,
  input  logic                 DIN_VALID,
  output logic                 DIN_READY,
  output logic                 SO,
  output logic                 SO_VALID,
  output logic                 FRAME_END,
  output logic                 UNDERRUN,
  output state_e               FSM_STATE
);

  localparam int CW = (C_FRAME_LEN > 1) ? $clog2(C_FRAME_LEN) : 1;
  localparam int S  = C_FRAME_LEN - C_BITS_IN;
  localparam logic [CW-1:0] SHIFT_START = CW'(S);

  logic [CW-1:0]        cnt;
  logic                 load_tick;
  logic                 load_next;
  logic                 frame_end;
  logic                 shift_phase;

  logic                 buf_full;
  logic [C_BITS_IN-1:0] buf_word;
  logic [C_BITS_IN-1:0] shift_reg;
  logic [C_BITS_IN-1:0] last_word;
  logic                 seq_valid;
  logic                 underrun_q;
  logic                 transfer;
  logic                 bypass;

  state_e state, state_next;

  p_s_frame_counter #(
    .C_BITS_IN   (C_BITS_IN),
    .C_FRAME_LEN (C_FRAME_LEN)
  ) u_frame_counter (
    .clk       (CK),
    .rst       (RST),
    .cnt       (cnt),
    .load_tick (load_tick),
    .load_next (load_next),
    .frame_end (frame_end)
  );

  assign shift_phase = (cnt >= SHIFT_START);

  // The buffer frees up in the load cycle, so a new word can be taken in
  // the same cycle the held one moves into the shifter.
  assign DIN_READY = !buf_full || load_tick;
  assign transfer  = DIN_VALID && DIN_READY;

  // A word arriving in the load cycle while the buffer is empty goes
  // straight into the shifter, so it still leaves in the current frame.
  assign bypass    = load_tick && !buf_full && transfer;

  // -------------------------------------------------------------------------
  // Frame-phase FSM (tracks the counter; one cycle ahead via load_next)
  // -------------------------------------------------------------------------
  always_ff @(posedge CK) begin
    if (RST) begin
      // With S == 1 the cycle right after reset is already the load cycle.
      state <= (S == 1) ? LOAD : IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (load_next) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (frame_end) state_next = (S == 1) ? LOAD : GAP;
      GAP:     if (load_next) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  assign FSM_STATE = state;

  // -------------------------------------------------------------------------
  // Hold buffer, shifter and underrun flag
  // -------------------------------------------------------------------------
  always_ff @(posedge CK) begin
    if (RST) begin
      buf_full   <= 1'b0;
      buf_word   <= '0;
      shift_reg  <= '0;
      last_word  <= '0;
      seq_valid  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;

      if (transfer && !bypass) begin
        buf_word <= DIN;
        buf_full <= 1'b1;
      end else if (load_tick) begin
        buf_full <= 1'b0;
      end

      if (load_tick) begin
        if (buf_full) begin
          shift_reg <= buf_word;
          last_word <= buf_word;
          seq_valid <= 1'b1;
        end else if (bypass) begin
          shift_reg <= DIN;
          last_word <= DIN;
          seq_valid <= 1'b1;
        end else begin
          underrun_q <= 1'b1;
`ifdef P_S_UNDERRUN_HOLD_EN
          shift_reg  <= last_word;
          seq_valid  <= 1'b1;
`else
          shift_reg  <= '0;
          seq_valid  <= 1'b0;
`endif
        end
      end else if (shift_phase) begin
        shift_reg <= {shift_reg[C_BITS_IN-2:0], 1'b0};
      end
    end
  end

  assign SO        = shift_phase && shift_reg[C_BITS_IN-1];
  assign SO_VALID  = shift_phase && seq_valid;
  assign FRAME_END = frame_end;
  assign UNDERRUN  = underrun_q;

endmodule

// File: tb/tb_p_s_converter.sv
// ---------------------------------------------------------------------------
// tb_p_s_converter
// Directed bench for p_s_converter with C_BITS_IN=8, C_FRAME_LEN=12 (S=4).
// Inputs change 1 time unit after the rising edge; outputs are checked at
// that same point, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_p_s_converter;
  import s_p_pkg::*;

  localparam int W = 8;
  localparam int L = 12;
  localparam int S = L - W;

  logic         CK;
  logic         RST;
  logic [W-1:0] DIN;
  logic         DIN_VALID;
  logic         DIN_READY;
  logic         SO;
  logic         SO_VALID;
  logic         FRAME_END;
  logic         UNDERRUN;
  state_e       FSM_STATE;

  int checks;
  int errors;

  p_s_converter #(
    .C_BITS_IN   (W),
    .C_FRAME_LEN (L)
  ) dut (
    .CK        (CK),
    .RST       (RST),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .DIN_READY (DIN_READY),
    .SO        (SO),
    .SO_VALID  (SO_VALID),
    .FRAME_END (FRAME_END),
    .UNDERRUN  (UNDERRUN),
    .FSM_STATE (FSM_STATE)
  );

  // clock / reset
  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Call at cnt == S; checks the whole shift phase and returns at cnt == 0.
  task automatic check_shift(input string tag, input logic [W-1:0] word,
                             input logic exp_valid, input logic exp_underrun);
    check_eq({tag, "_underrun"}, 32'(UNDERRUN), 32'(exp_underrun));
    for (int k = 0; k < W; k++) begin
      check_eq($sformatf("%s_so_b%0d", tag, k), 32'(SO), 32'(word[W-1-k]));
      check_eq($sformatf("%s_sov_b%0d", tag, k), 32'(SO_VALID), 32'(exp_valid));
      check_eq($sformatf("%s_fe_b%0d", tag, k), 32'(FRAME_END),
               32'(k == W - 1));
      step();
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    RST       = 1'b1;
    DIN       = '0;
    DIN_VALID = 1'b0;

    // 1. reset for two cycles, then release; now at cnt 0
    step_n(2);
    RST = 1'b0;
    check_eq("rst_so", 32'(SO), 32'd0);
    check_eq("rst_so_valid", 32'(SO_VALID), 32'd0);
    check_eq("rst_underrun", 32'(UNDERRUN), 32'd0);
    check_eq("rst_ready", 32'(DIN_READY), 32'd1);
    check_eq("rst_state", 32'(FSM_STATE), 32'(IDLE));
    for (int c = 0; c < L; c++) begin
      check_eq($sformatf("rst_fe_c%0d", c), 32'(FRAME_END), 32'(c == L - 1));
      if (c == S) begin
        check_eq("rst_first_underrun", 32'(UNDERRUN), 32'd1);
        check_eq("rst_first_sov", 32'(SO_VALID), 32'd0);
      end
      step();
    end

    // 2. single word 0xA5 accepted at cnt 1
    step();
    DIN       = 8'hA5;
    DIN_VALID = 1'b1;
    check_eq("a5_ready", 32'(DIN_READY), 32'd1);
    step();
    DIN_VALID = 1'b0;
    check_eq("a5_ready_full", 32'(DIN_READY), 32'd0);
    step_n(2);
    check_shift("a5", 8'hA5, 1'b1, 1'b0);

    // 3. back-to-back: 0x3C at cnt 0, 0xC3 held from cnt 1
    DIN       = 8'h3C;
    DIN_VALID = 1'b1;
    check_eq("b2b_ready_c0", 32'(DIN_READY), 32'd1);
    step();
    DIN = 8'hC3;
    check_eq("b2b_ready_c1", 32'(DIN_READY), 32'd0);
    step();
    check_eq("b2b_ready_c2", 32'(DIN_READY), 32'd0);
    step();
    check_eq("b2b_ready_c3", 32'(DIN_READY), 32'd1);
    check_eq("b2b_state_load", 32'(FSM_STATE), 32'(LOAD));
    step();
    DIN_VALID = 1'b0;
    check_eq("b2b_state_shift", 32'(FSM_STATE), 32'(SHIFT));
    check_shift("b2b_3c", 8'h3C, 1'b1, 1'b0);
    check_eq("b2b_ready_f2", 32'(DIN_READY), 32'd0);
    check_eq("b2b_state_gap", 32'(FSM_STATE), 32'(GAP));
    step_n(S);
    check_shift("b2b_c3", 8'hC3, 1'b1, 1'b0);

    // 4. 0x5A, then a frame with no word
    step();
    DIN       = 8'h5A;
    DIN_VALID = 1'b1;
    step();
    DIN_VALID = 1'b0;
    step_n(2);
    check_shift("ur_5a", 8'h5A, 1'b1, 1'b0);
    step_n(S);
`ifdef P_S_UNDERRUN_HOLD_EN
    check_shift("ur_hold", 8'h5A, 1'b1, 1'b1);
`else
    check_shift("ur_zero", 8'h00, 1'b0, 1'b1);
`endif

    // 5. reset at cnt 7 of a 0xFF frame
    step();
    DIN       = 8'hFF;
    DIN_VALID = 1'b1;
    step();
    DIN_VALID = 1'b0;
    step_n(2);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("mid_so_b%0d", k), 32'(SO), 32'd1);
      step();
    end
    RST = 1'b1;
    check_eq("mid_so_c7", 32'(SO), 32'd1);
    check_eq("mid_sov_c7", 32'(SO_VALID), 32'd1);
    step();
    RST = 1'b0;
    check_eq("mid_so_after", 32'(SO), 32'd0);
    check_eq("mid_sov_after", 32'(SO_VALID), 32'd0);
    check_eq("mid_ready_after", 32'(DIN_READY), 32'd1);
    check_eq("mid_fe_after", 32'(FRAME_END), 32'd0);
    // counter restarted at 0: load is S-1 cycles away, shift starts at S
    step_n(S);
`ifdef P_S_UNDERRUN_HOLD_EN
    check_shift("mid_next", 8'h00, 1'b1, 1'b1);
`else
    check_shift("mid_next", 8'h00, 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
